// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider controller family.
// Holds the controller state enum, the reset ratio and the smallest
// ratio the counter can produce a meaningful waveform with.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        STOP
    } ctrl_state_t;

    localparam int DEF_RATIO_C = 10;
    localparam int MIN_RATIO_C = 2;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration bus between a register-bank master and the divider
// controller: a new divide ratio offered over valid/ready, plus the
// done/err pulses that report how the request was resolved.
interface clk_div_ctrl_if #(
    parameter int RATIO_W = 8
);

    logic               cfg_valid;
    logic [RATIO_W-1:0] cfg_ratio;
    logic               cfg_ready;
    logic               cfg_done;
    logic               cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ratio,
        input  cfg_ready,
        input  cfg_done,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ratio,
        output cfg_ready,
        output cfg_done,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_core.sv
// Divide-by-N counter and registered divided clock.
// The count runs 0..ratio-1; the output is high for the first ratio/2
// counts of every period. The controller steers it with clear (park at
// zero, output low), load (start a fresh period, output high) and run.
// The ratio input is assumed to be at least 2.
module clk_div_core #(
    parameter int RATIO_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               run,
    input  logic [RATIO_W-1:0] ratio,
    output logic               div_clk,
    output logic               tick
);

    localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);

    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] cnt_inc;
    logic [RATIO_W-1:0] half;
    logic               last;

    assign cnt_inc = cnt + ONE;
    assign half    = ratio >> 1;
    assign last    = (cnt == (ratio - ONE));
    assign tick    = run && last;

    // Counter and divided clock advance together so the output never lags the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            div_clk <= 1'b1;
        end else if (run) begin
            if (last) begin
                cnt     <= '0;
                div_clk <= 1'b1;
            end else begin
                cnt     <= cnt_inc;
                div_clk <= (cnt_inc < half);
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the synchronous clock divider.
// Sequences enable/disable and ratio changes so they only land on period
// boundaries, keeping the divided clock glitch-free. A ratio written while
// idle applies on the next edge; one written while counting is parked in a
// shadow register until the current period ends.
// Optional build macro CLK_DIV_CTRL_ERR_EN: when defined, ratios below 2 are
// rejected with an err pulse; otherwise they are clamped to 2.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int RATIO_W   = 8,
    parameter int DEF_RATIO = DEF_RATIO_C
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    clk_div_ctrl_if.slave        cfg,
    output logic                 o_clk,
    output logic                 o_period_tick,
    output logic                 o_busy
);

    localparam logic [RATIO_W-1:0] MIN_RATIO   = RATIO_W'(MIN_RATIO_C);
    localparam logic [RATIO_W-1:0] RESET_RATIO = RATIO_W'(DEF_RATIO);

    ctrl_state_t        state;
    ctrl_state_t        state_next;
    logic [RATIO_W-1:0] ratio;
    logic [RATIO_W-1:0] shadow;
    logic [RATIO_W-1:0] cfg_eff;
    logic               accept;
    logic               take;
    logic               load_cfg;
    logic               load_shadow;
    logic               capture;
    logic               done_q;
    logic               done_next;
    logic               core_clear;
    logic               core_load;
    logic               core_run;
    logic               tick;

    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg.cfg_ready = (state != PEND);
    assign cfg.cfg_done  = done_q;
    assign core_run      = (state != IDLE);
    assign o_busy        = core_run;
    assign o_period_tick = tick;

`ifdef CLK_DIV_CTRL_ERR_EN
    logic err_q;
    logic reject;

    assign take        = accept && (cfg.cfg_ratio >= MIN_RATIO);
    assign reject      = accept && (cfg.cfg_ratio < MIN_RATIO);
    assign cfg_eff     = cfg.cfg_ratio;
    assign cfg.cfg_err = err_q;

    // Rejected requests complete the handshake and are reported one edge later
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
        end
    end
`else
    assign take        = accept;
    assign cfg_eff     = (cfg.cfg_ratio < MIN_RATIO) ? MIN_RATIO : cfg.cfg_ratio;
    assign cfg.cfg_err = 1'b0;
`endif

    // Next-state decode: stops and ratio swaps are only honoured on the last count
    always_comb begin
        state_next  = state;
        core_clear  = 1'b0;
        core_load   = 1'b0;
        load_cfg    = 1'b0;
        load_shadow = 1'b0;
        capture     = 1'b0;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    load_cfg  = 1'b1;
                    done_next = 1'b1;
                end
                if (i_en) begin
                    state_next = RUN;
                    core_load  = 1'b1;
                end
            end
            RUN: begin
                if (take) begin
                    capture    = 1'b1;
                    state_next = PEND;
                end else if (!i_en) begin
                    if (tick) begin
                        state_next = IDLE;
                        core_clear = 1'b1;
                    end else begin
                        state_next = STOP;
                    end
                end
            end
            PEND: begin
                if (tick) begin
                    load_shadow = 1'b1;
                    done_next   = 1'b1;
                    if (i_en) begin
                        state_next = RUN;
                        core_load  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        core_clear = 1'b1;
                    end
                end
            end
            STOP: begin
                if (take) begin
                    capture    = 1'b1;
                    state_next = PEND;
                end else if (i_en) begin
                    state_next = RUN;
                end else if (tick) begin
                    state_next = IDLE;
                    core_clear = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                core_clear = 1'b1;
            end
        endcase
    end

    // State, active ratio, shadow ratio and done pulse; reset drops any pending request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            ratio  <= RESET_RATIO;
            shadow <= RESET_RATIO;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
            if (load_cfg) begin
                ratio <= cfg_eff;
            end else if (load_shadow) begin
                ratio <= shadow;
            end
            if (capture) begin
                shadow <= cfg_eff;
            end
        end
    end

    clk_div_core #(
        .RATIO_W (RATIO_W)
    ) u_core (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (core_clear),
        .load    (core_load),
        .run     (core_run),
        .ratio   (ratio),
        .div_clk (o_clk),
        .tick    (tick)
    );

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the synchronous clock divider family. It owns a programmable divide-by-N counter and sequences enable/disable and ratio changes so they take effect only at period boundaries, which keeps the divided output glitch-free. Configuration arrives from a register-bank master over a valid/ready handshake. o_clk feeds downstream slow-clock logic as a clock or a clock-like strobe.

Parameters:
RATIO_W, 8, width of the divide-ratio field
DEF_RATIO, 10, ratio loaded at reset (must be >= 2)

Ports:
i_clk  input  1  source clock; all logic rising-edge
i_rst_n  input  1  asynchronous reset, active low
i_en  input  1  level; 1 = divider running, 0 = stop at the next period boundary
i_cfg_valid  input  1  new ratio offered
i_cfg_ratio  input  RATIO_W  requested divide ratio N
o_cfg_ready  output  1  controller can accept a ratio
o_cfg_done  output  1  one-cycle pulse on the cycle the new ratio takes effect
o_cfg_err  output  1  one-cycle pulse when an illegal ratio is rejected (feature-dependent)
o_clk  output  1  divided clock, registered
o_period_tick  output  1  one-cycle pulse on the last i_clk cycle of each o_clk period
o_busy  output  1  high in RUN, PEND or STOP

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, ratio=DEF_RATIO, cnt=0, o_clk=0, o_cfg_ready=1, o_cfg_done/o_cfg_err/o_period_tick/o_busy=0.
- Counter: cnt runs 0..N-1 and wraps to 0. o_clk updates on the same edge as cnt: o_clk=1 while cnt < (N>>1), else 0. N=10 gives 5 high/5 low; N=3 gives 1 high/2 low. o_period_tick=1 while cnt==N-1 in RUN/PEND/STOP.
- States:
  - IDLE: cnt held 0, o_clk=0. If i_en=1, go to RUN next edge with cnt=0 and o_clk=1, so o_clk rises one cycle after i_en is sampled.
  - RUN: free-running count. If i_en=0, go to STOP. If a config handshake is accepted, go to PEND.
  - PEND: new ratio held in a shadow register, o_cfg_ready=0. At cnt==N-1 the next edge loads the shadow into ratio, sets cnt=0, pulses o_cfg_done and returns to RUN. If i_en=0 in PEND, the change still applies at the boundary and the state goes to IDLE.
  - STOP: count continues to the end of the period. At cnt==N-1 the next edge goes to IDLE with o_clk=0. If i_en returns to 1 before the boundary, return to RUN with no truncation.
- Handshake: accept when i_cfg_valid && o_cfg_ready. o_cfg_ready=1 in IDLE, RUN and STOP; 0 in PEND. An accept in IDLE loads ratio on the next edge and pulses o_cfg_done on that edge. An accept in STOP takes effect at the boundary, same as PEND.
- Simultaneous events: a config accept and i_en falling in the same RUN cycle resolve to PEND; the stop is honoured at that boundary. A period never ends early and a new period never mixes old and new N.
- Reset mid-period: o_clk drops to 0 immediately and any pending shadow is discarded.

Optional Feature:
CLK_DIV_CTRL_ERR_EN
- Defined: i_cfg_ratio < 2 is rejected. The handshake still completes, o_cfg_err pulses on the next edge, and ratio and state are unchanged.
- Undefined: ratios < 2 are clamped to 2 and processed normally. o_cfg_err is tied 0.

Decomposition:
- Package clk_div_pkg holds the state enum (IDLE, RUN, PEND, STOP), DEF_RATIO_C and the MIN_RATIO_C=2 constant.
- Sub-module clk_div_core holds the counter, o_clk and o_period_tick, with load/clear/enable inputs. The FSM and handshake stay in clk_div_ctrl.

Test Plan:
- Reset release, i_en=1 -> o_clk rises 1 cycle later; period 10 cycles, 5 high/5 low; o_period_tick every 10th cycle.
- While running at N=10, write N=4 at cnt=3 -> o_cfg_ready low; old period completes; o_cfg_done at the first cnt=0 with N=4; then 2 high/2 low.
- i_en=0 at cnt=2 -> o_clk keeps toggling to cnt=9, then IDLE with o_clk=0 and o_busy=0; re-raise i_en at cnt=6 in a second run -> no stop occurs.
- Write N=7 in IDLE -> o_cfg_done next cycle; enable -> 3 high/4 low.
- Write N=1 -> with CLK_DIV_CTRL_ERR_EN: o_cfg_err pulse, N unchanged. Without it: N=2, output toggles every cycle.
- Assert i_rst_n=0 mid-period while PEND -> o_clk=0 immediately; after release N=10 and state IDLE.
